// File: rtl/dpm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpm_pkg
// Brief    : Shared widths, frame defaults, FSM states and point record
//            for the DrawPoint arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dpm_pkg;

    localparam int POS_W = 9;
    localparam int RGB_W = 12;
    localparam int HRES  = 320;
    localparam int VRES  = 240;

    typedef enum logic [0:0] {
        ARB = 1'b0,
        GAP = 1'b1
    } state_t;

    typedef struct packed {
        logic [POS_W-1:0] posx;
        logic [POS_W-1:0] posy;
        logic [RGB_W-1:0] rgb;
    } point_t;

endpackage
`default_nettype wire

// File: rtl/dpm_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : dpm_rr_picker
// Brief    : Combinational rotating-priority encoder; with a lock enabled only
//            the owner is eligible.
// Revision : 1.0 - initial release
// ============================================================================
module dpm_rr_picker
    import dpm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               lock_en,
    input  logic [IDX_W-1:0]   lock_owner,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found;
    int   cand;

    // Scan starts one past the last winner so the last winner ranks lowest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[IDX_W'(cand)] &&
                (!lock_en || int'(lock_owner) == cand)) begin
                found                = 1'b1;
                grant[IDX_W'(cand)]  = 1'b1;
                grant_idx            = IDX_W'(cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpm_point_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dpm_point_arbiter
// Brief    : Round-robin share of one DrawPoint sink with lock, pulse spacing
//            and out-of-frame drop counting.
// Revision : 1.0 - initial release
// ============================================================================
module dpm_point_arbiter
    import dpm_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int H_RES        = HRES,
    parameter int V_RES        = VRES,
    parameter int GAP_CYCLES   = 2,
    parameter int LOCK_MAX     = 16,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                  csi_clock_clk,
    input  logic                  rsi_reset_reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ*9-1:0]  req_posx,
    input  logic [NUM_REQ*9-1:0]  req_posy,
    input  logic [NUM_REQ*12-1:0] req_rgb,
    output logic                  coe_dpm_ul1Clock,
    output logic                  coe_dpm_ul1Reset_n,
    output logic                  coe_dpm_ul1Update,
    output logic [8:0]            coe_dpm_ul9PosX,
    output logic [8:0]            coe_dpm_ul9PosY,
    output logic [11:0]           coe_dpm_ul12Rgb12Data,
    output logic [15:0]           drop_count,
    output logic [2:0]            grant_id,
    output logic                  lock_active
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, lock_owner, win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [15:0]        gap_cnt, lock_cnt, idle_cnt;
    logic               accept, in_range, lock_bit, owner_idle;
    point_t             pick, issued;

    logic [POS_W-1:0] posx_arr [NUM_REQ];
    logic [POS_W-1:0] posy_arr [NUM_REQ];
    logic [RGB_W-1:0] rgb_arr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign posx_arr[i] = req_posx[i*POS_W +: POS_W];
        assign posy_arr[i] = req_posy[i*POS_W +: POS_W];
        assign rgb_arr[i]  = req_rgb[i*RGB_W +: RGB_W];
    end

    dpm_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req        (req_valid),
        .ptr        (ptr),
        .lock_en    (lock_active),
        .lock_owner (lock_owner),
        .grant      (win_onehot),
        .grant_idx  (win_idx)
    );

    assign coe_dpm_ul1Clock      = csi_clock_clk;
    assign coe_dpm_ul1Reset_n    = ~rsi_reset_reset;
    assign coe_dpm_ul9PosX       = issued.posx;
    assign coe_dpm_ul9PosY       = issued.posy;
    assign coe_dpm_ul12Rgb12Data = issued.rgb;

    assign req_ready  = (state == ARB && !rsi_reset_reset) ? win_onehot : '0;
    assign accept     = |req_ready;
    assign lock_bit   = req_lock[win_idx];
    assign owner_idle = lock_active && (state == ARB) && !req_valid[lock_owner];

    always_comb begin
        pick.posx = posx_arr[win_idx];
        pick.posy = posy_arr[win_idx];
        pick.rgb  = rgb_arr[win_idx];
        in_range  = (int'(pick.posx) < H_RES) && (int'(pick.posy) < V_RES);
    end

    always_ff @(posedge csi_clock_clk) begin
        if (rsi_reset_reset) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropped points never open a gap: the sink saw no pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (accept && in_range && GAP_CYCLES > 1) state_nxt = GAP;
            GAP:     if (gap_cnt >= 16'(GAP_CYCLES - 2)) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge csi_clock_clk) begin
        if (rsi_reset_reset) begin
            coe_dpm_ul1Update <= 1'b0;
            issued            <= '0;
            drop_count        <= '0;
            grant_id          <= '0;
            lock_active       <= 1'b0;
            lock_owner        <= '0;
            ptr               <= IDX_W'(NUM_REQ - 1);
            gap_cnt           <= '0;
            lock_cnt          <= '0;
            idle_cnt          <= '0;
        end else begin
            coe_dpm_ul1Update <= accept && in_range;
            gap_cnt           <= (state == GAP) ? gap_cnt + 16'd1 : '0;

            if (accept && in_range) begin
                issued <= pick;
            end
            if (accept && !in_range && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end

            if (accept) begin
                ptr      <= win_idx;
                grant_id <= 3'(win_idx);
                idle_cnt <= '0;
                if (!lock_active) begin
                    if (lock_bit && LOCK_MAX > 1) begin
                        lock_active <= 1'b1;
                        lock_owner  <= win_idx;
                        lock_cnt    <= 16'd1;
                    end
                end else if (!lock_bit || lock_cnt >= 16'(LOCK_MAX - 1)) begin
                    lock_active <= 1'b0;
                    lock_cnt    <= '0;
                end else begin
                    lock_cnt <= lock_cnt + 16'd1;
                end
            end else if (owner_idle) begin
                // Abandoned lock: hand priority to everyone after the owner.
                if (idle_cnt >= 16'(LOCK_TIMEOUT - 1)) begin
                    lock_active <= 1'b0;
                    lock_cnt    <= '0;
                    idle_cnt    <= '0;
                    ptr         <= lock_owner;
                end else begin
                    idle_cnt <= idle_cnt + 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dpm_point_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpm_point_arbiter
// Brief    : Self-checking bench: vector table, scoreboard of issued points,
//            and hand sequences for round-robin, lock, timeout and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpm_point_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    valid, ready, lock;
    logic [N*9-1:0]  posx, posy;
    logic [N*12-1:0] rgb;
    logic            up_clk, up_rstn, update, lact;
    logic [8:0]      ox, oy;
    logic [11:0]     orgb;
    logic [15:0]     drops;
    logic [2:0]      gid;

    always #5 clk = ~clk;

    dpm_point_arbiter #(
        .NUM_REQ(N), .H_RES(320), .V_RES(240),
        .GAP_CYCLES(2), .LOCK_MAX(16), .LOCK_TIMEOUT(64)
    ) dut (
        .csi_clock_clk         (clk),
        .rsi_reset_reset       (rst),
        .req_valid             (valid),
        .req_ready             (ready),
        .req_lock              (lock),
        .req_posx              (posx),
        .req_posy              (posy),
        .req_rgb               (rgb),
        .coe_dpm_ul1Clock      (up_clk),
        .coe_dpm_ul1Reset_n    (up_rstn),
        .coe_dpm_ul1Update     (update),
        .coe_dpm_ul9PosX       (ox),
        .coe_dpm_ul9PosY       (oy),
        .coe_dpm_ul12Rgb12Data (orgb),
        .drop_count            (drops),
        .grant_id              (gid),
        .lock_active           (lact)
    );

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [11:0] c;
    } pt_t;

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [11:0] c;
        logic        upd;
    } vec_t;

    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    pt_t  sb_q[$];
    int   xfer_id[$];
    int   xfer_cyc[$];
    pt_t  mon_pt;
    pt_t  exp_pt;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop on each Update pulse, push on each in-frame transfer.
    always @(negedge clk) begin
        if (update === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_update", 32'(update), 32'd0);
            end else begin
                exp_pt = sb_q.pop_front();
                check("sb_posx", 32'(ox), 32'(exp_pt.x));
                check("sb_posy", 32'(oy), 32'(exp_pt.y));
                check("sb_rgb", 32'(orgb), 32'(exp_pt.c));
            end
        end
        check("ready_onehot", 32'($countones(ready) <= 1), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (valid[i] === 1'b1 && ready[i] === 1'b1) begin
                xfer_id.push_back(i);
                xfer_cyc.push_back(cyc);
                mon_pt.x = posx[9*i +: 9];
                mon_pt.y = posy[9*i +: 9];
                mon_pt.c = rgb[12*i +: 12];
                if (int'(mon_pt.x) < 320 && int'(mon_pt.y) < 240) sb_q.push_back(mon_pt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pt(input int i, input int x, input int y, input int c);
        posx[9*i +: 9]   = 9'(x);
        posy[9*i +: 9]   = 9'(y);
        rgb[12*i +: 12]  = 12'(c);
    endtask

    task automatic do_reset();
        step();
        step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        rst   = 1'b1;
        valid = '1;
        lock  = '0;
        #1;
        check("reset_ready_low", 32'(ready), 32'd0);
        check("reset_n_low", 32'(up_rstn), 32'd0);
        step();
        step();
        rst   = 1'b0;
        valid = '0;
        #1;
        sb_q.delete();
        xfer_id.delete();
        xfer_cyc.delete();
        check("reset_update", 32'(update), 32'd0);
        check("reset_drops", 32'(drops), 32'd0);
        check("reset_gid", 32'(gid), 32'd0);
        check("reset_lock", 32'(lact), 32'd0);
        check("reset_n_high", 32'(up_rstn), 32'd1);
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int k;
        k = 0;
        while (xfer_id.size() < n && k < budget) begin
            step();
            k++;
        end
        if (xfer_id.size() < n) check("xfer_wait_expired", 32'(xfer_id.size()), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_drops;
        int seen;
        int exp_rr[5];
        rst = 1'b1; valid = '0; lock = '0; posx = '0; posy = '0; rgb = '0;

        vecs[0] = '{9'd10,  9'd20,  12'hF00, 1'b1};
        vecs[1] = '{9'd319, 9'd239, 12'h0AB, 1'b1};
        vecs[2] = '{9'd320, 9'd0,   12'h123, 1'b0};
        vecs[3] = '{9'd0,   9'd240, 12'h456, 1'b0};
        vecs[4] = '{9'd0,   9'd0,   12'hFFF, 1'b1};
        vecs[5] = '{9'd511, 9'd511, 12'h000, 1'b0};
        vecs[6] = '{9'd100, 9'd239, 12'h5A5, 1'b1};
        vecs[7] = '{9'd319, 9'd240, 12'h777, 1'b0};

        // Single-point vectors from requester 0.
        do_reset();
        check("clk_mirror", 32'(up_clk), 32'(clk));
        exp_drops = 0;
        for (int v = 0; v < 8; v++) begin
            set_pt(0, int'(vecs[v].x), int'(vecs[v].y), int'(vecs[v].c));
            valid[0] = 1'b1;
            #1;
            check("vec_ready", 32'(ready[0]), 32'd1);
            step();
            valid[0] = 1'b0;
            check("vec_update", 32'(update), 32'(vecs[v].upd));
            check("vec_gid", 32'(gid), 32'd0);
            if (!vecs[v].upd) exp_drops++;
            step();
            check("vec_update_low", 32'(update), 32'd0);
        end
        check("vec_drops", 32'(drops), 32'(exp_drops));

        // Back-to-back drops, then an in-frame point on the very next cycle.
        set_pt(0, 320, 0, 12'h111); valid[0] = 1'b1; #1;
        check("b2b_ready0", 32'(ready[0]), 32'd1);
        step();
        set_pt(0, 0, 240, 12'h222); #1;
        check("b2b_ready1", 32'(ready[0]), 32'd1);
        step();
        set_pt(0, 7, 8, 12'hABC); #1;
        check("b2b_ready2", 32'(ready[0]), 32'd1);
        step();
        valid[0] = 1'b0;
        check("b2b_update", 32'(update), 32'd1);
        check("b2b_drops", 32'(drops), 32'(exp_drops + 2));

        // Round-robin across all four requesters.
        do_reset();
        exp_rr = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) set_pt(i, 10 * i + 1, 5 * i + 2, 16'h100 * i + i);
        valid = '1;
        seen = 0;
        for (int c = 0; c < 20 && seen < 5; c++) begin
            step();
            if (xfer_id.size() > seen) begin
                seen = xfer_id.size();
                if (seen <= 5) check("rr_grant_id", 32'(gid), 32'(exp_rr[seen-1]));
            end
        end
        valid = '0;
        check("rr_count", 32'(xfer_id.size()), 32'd5);
        for (int k = 0; k < xfer_id.size() && k < 5; k++) begin
            check("rr_order", 32'(xfer_id[k]), 32'(exp_rr[k]));
            if (k > 0) check("rr_spacing", 32'(xfer_cyc[k] - xfer_cyc[k-1]), 32'd2);
        end

        // Lock held by requester 1 up to LOCK_MAX points while 2 waits.
        do_reset();
        set_pt(1, 50, 60, 12'h0F0);
        set_pt(2, 70, 80, 12'h00F);
        valid = 4'b0110;
        lock  = 4'b0010;
        wait_xfers(1, 5);
        check("lock_started", 32'(lact), 32'd1);
        wait_xfers(18, 60);
        valid = '0;
        lock  = '0;
        for (int k = 0; k < xfer_id.size() && k < 18; k++) begin
            check("lock_order", 32'(xfer_id[k]), (k == 16) ? 32'd2 : 32'd1);
        end

        // Lock abandoned by its owner: released after 64 idle ARB cycles.
        do_reset();
        set_pt(1, 1, 1, 12'h123);
        set_pt(3, 3, 3, 12'h321);
        valid = 4'b1010;
        lock  = 4'b0010;
        wait_xfers(1, 5);
        valid[1] = 1'b0;
        lock     = '0;
        check("timeout_lock_held", 32'(lact), 32'd1);
        wait_xfers(2, 100);
        valid = '0;
        if (xfer_id.size() >= 2) begin
            check("timeout_winner", 32'(xfer_id[1]), 32'd3);
            check("timeout_latency", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd66);
        end
        check("timeout_lock_released", 32'(lact), 32'd0);

        // Reset asserted in GAP with a lock held and a nonzero drop count.
        do_reset();
        set_pt(0, 400, 0, 12'h999);
        valid = 4'b0001;
        #1;
        check("rst_drop_ready", 32'(ready[0]), 32'd1);
        step();
        valid = '0;
        check("rst_drop_count", 32'(drops), 32'd1);
        for (int i = 0; i < N; i++) set_pt(i, 20 + i, 30 + i, 12'h800 + i);
        valid = '1;
        lock  = 4'b0010;
        wait_xfers(2, 5);
        if (xfer_id.size() >= 2) check("rst_lock_owner", 32'(xfer_id[1]), 32'd1);
        check("rst_pre_lock", 32'(lact), 32'd1);
        check("rst_pre_update", 32'(update), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_ready_low", 32'(ready), 32'd0);
        step();
        check("rst_update_low", 32'(update), 32'd0);
        check("rst_lock_low", 32'(lact), 32'd0);
        check("rst_drops_clr", 32'(drops), 32'd0);
        rst  = 1'b0;
        lock = '0;
        #1;
        check("rst_first_ready", 32'(ready), 32'b0001);
        step();
        valid = '0;
        check("rst_first_gid", 32'(gid), 32'd0);
        step();
        step();
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dpm_point_arbiter.md
Name: dpm_point_arbiter

Overview:
- Shares one DrawPoint sink (the coe_dpm_* point-update bus) between NUM_REQ pixel producers, for example the Avalon command slave, the camera pixel path and a fill engine.
- Arbitration is round-robin. An optional per-requester lock holds the grant for line/run drawing.
- Enforces a minimum spacing between update pulses for the sink, and drops points outside the frame, counting the drops.
- Sits between the producers and the display DrawPoint input, in the command clock domain.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- H_RES, 320: horizontal resolution in px; points with posx >= H_RES are dropped.
- V_RES, 240: vertical resolution in px; points with posy >= V_RES are dropped.
- GAP_CYCLES, 2: minimum cycles between consecutive update pulses; must be >= 1.
- LOCK_MAX, 16: maximum consecutive points under one lock.
- LOCK_TIMEOUT, 64: idle cycles after which a held lock is released.

Ports:
- csi_clock_clk, in, 1: clock.
- rsi_reset_reset, in, 1: synchronous active-high reset.
- req_valid, in, NUM_REQ: point offered by requester i.
- req_ready, out, NUM_REQ: point accepted this cycle (transfer = valid & ready).
- req_lock, in, NUM_REQ: keep the grant after this point.
- req_posx, in, NUM_REQ*9: X position, slice i = [9i+8:9i].
- req_posy, in, NUM_REQ*9: Y position, same slicing.
- req_rgb, in, NUM_REQ*12: RGB444 colour, slice i = [12i+11:12i].
- coe_dpm_ul1Clock, out, 1: equals csi_clock_clk.
- coe_dpm_ul1Reset_n, out, 1: equals ~rsi_reset_reset.
- coe_dpm_ul1Update, out, 1: one-cycle point-write strobe.
- coe_dpm_ul9PosX, out, 9: X of the issued point.
- coe_dpm_ul9PosY, out, 9: Y of the issued point.
- coe_dpm_ul12Rgb12Data, out, 12: colour of the issued point.
- drop_count, out, 16: saturating count of out-of-range points.
- grant_id, out, 3: index of the last accepted requester.
- lock_active, out, 1: a lock is currently held.

Behaviour:
- Single clock domain; reset is synchronous and active-high. All logic is sampled on the rising edge of csi_clock_clk.
- Reset values:
  - Update, PosX, PosY, Rgb12Data, drop_count, grant_id, lock_active = 0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - State = ARB; gap/lock/timeout counters = 0.
  - req_ready is forced to 0 while reset is high.
- States:
  - ARB: may accept.
  - GAP: spacing wait; req_ready = 0.
- Winner selection in ARB:
  - Unlocked: the first valid requester scanning ptr+1, ptr+2, ... modulo NUM_REQ.
  - Locked: only the lock owner is eligible.
  - req_ready is one-hot of the winner, combinational from req_valid and the state; all zeros if there is no eligible valid.
- In-range transfer at cycle t:
  - At t+1: Update = 1 and Pos/Rgb registers = the accepted point.
  - ptr and grant_id are updated to the winner.
  - If GAP_CYCLES > 1, go to GAP for GAP_CYCLES-1 cycles, then ARB. If GAP_CYCLES = 1, stay in ARB; one point per cycle is possible.
  - Pos/Rgb hold their values until the next issued point. Update is high for exactly one cycle per issued point.
- Out-of-range transfer (posx >= H_RES or posy >= V_RES):
  - The point is accepted: ready is high and the handshake completes.
  - No Update; drop_count increments and saturates at 16'hFFFF.
  - Stays in ARB with no gap. The pointer and lock rules apply as for an in-range point.
- Lock:
  - Starts when an accepted point has req_lock[w] = 1 and no lock is active; lock_cnt = 1.
  - Each further accepted point from the owner with req_lock = 1 increments lock_cnt.
  - Releases when:
    - the owner's accepted point has req_lock = 0 (that point is still issued), or
    - lock_cnt reaches LOCK_MAX (the LOCK_MAX-th point is issued, then release), or
    - the owner has req_valid = 0 for LOCK_TIMEOUT consecutive ARB cycles.
  - On release, the RR pointer = owner, so others get priority next.
  - lock_active mirrors the held state.
- Timeout counter: counts only in ARB with lock held and owner idle; clears on any owner transfer.
- Simultaneous valids with no lock: exactly one is granted per ARB cycle; the others wait with ready = 0 and must hold their data (requester responsibility).
- Reset mid-operation: Update is 0 on the cycle after reset is sampled; the pending gap and lock are discarded; drop_count clears.
- Requesters must not change a point while valid & !ready. The block samples data only on transfer.

Decomposition:
- Package dpm_pkg:
  - Widths: 9 for position, 12 for RGB.
  - Default HRES = 320 and VRES = 240.
  - State enum {ARB, GAP}.
  - A point struct {posx, posy, rgb}.
- Sub-module dpm_rr_picker: a purely combinational rotating priority encoder.
  - Inputs: request vector, pointer, lock enable/owner.
  - Outputs: one-hot grant and index.
  - Parameterised by NUM_REQ.

Test Plan:
- Reset, then req0 offers (10,20,12'hF00) with GAP_CYCLES = 2 -> ready0 high at cycle t, Update = 1 at t+1 with PosX = 10, PosY = 20, Rgb = F00; Update low at t+2.
- req0..3 all valid continuously, no lock, GAP_CYCLES = 2 -> grant order 0,1,2,3,0; one Update every 2 cycles; grant_id follows that order.
- req1 locked for 20 points with LOCK_MAX = 16 while req2 is valid -> 16 consecutive req1 points, then req2 granted, then req1 resumes.
- req1 locks, then drops valid for 64 cycles while req3 is valid -> req3 granted on the cycle after the timeout; lock_active falls.
- req0 offers (320,0) and (0,240) -> both accepted, no Update, drop_count = 2; a following in-range point is accepted on the next cycle.
- Assert reset during GAP with a lock held -> Update = 0, lock_active = 0, drop_count = 0; the first point after reset goes to req0 when all are valid.
